// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between fetch (instruction reads)
// and execute (data loads/stores). Data wins contention unless fetch has been
// denied STARVE_MAX consecutive cycles. Read data returns one cycle after grant
// and is routed to the requester that owned the read.
module sram_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    // execute-stage data port
    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    // fetch-stage instruction port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    // SRAM macro port
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    // statistics
    output logic [15:0] conflict_cnt
);

    localparam int unsigned STARVE_W   = 4;
    localparam int unsigned CONFLICT_W = 16;
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [CONFLICT_W-1:0] conflict_cnt_q, conflict_cnt_d;
    logic                  rd_d_q, rd_d_d;
    logic                  rd_i_q, rd_i_d;
    logic                  fetch_due;

    // Grant decision: data priority, fetch forced once its starvation limit is hit
    always_comb begin
        d_gnt     = 1'b0;
        i_gnt     = 1'b0;
        fetch_due = (starve_cnt_q >= STARVE_LIM);
        if (!reset) begin
            if (d_req && i_req) begin
                if (fetch_due) begin
                    i_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    // SRAM request mux; data-side payload is parked on the bus when idle
    always_comb begin
        ram_en    = d_gnt | i_gnt;
        ram_we    = d_gnt ? d_we : 4'h0;
        ram_addr  = i_gnt ? i_addr : d_addr;
        ram_wdata = d_wdata;
    end

    // Next-state for read ownership, starvation and conflict counters
    always_comb begin
        rd_d_d         = d_gnt && (d_we == 4'h0);
        rd_i_d         = i_gnt;
        starve_cnt_d   = '0;
        conflict_cnt_d = conflict_cnt_q;
        if (i_req && !i_gnt) begin
            if (starve_cnt_q >= STARVE_LIM) begin
                starve_cnt_d = STARVE_LIM;
            end else begin
                starve_cnt_d = starve_cnt_q + STARVE_W'(1);
            end
        end
        if (d_req && i_req && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + CONFLICT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_d_q         <= 1'b0;
            rd_i_q         <= 1'b0;
            starve_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            rd_d_q         <= rd_d_d;
            rd_i_q         <= rd_i_d;
            starve_cnt_q   <= starve_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Response routing: read data goes only to the owner of last cycle's read
    always_comb begin
        d_rvalid     = rd_d_q;
        i_rvalid     = rd_i_q;
        d_rdata      = rd_d_q ? ram_rdata : 32'h0;
        i_rdata      = rd_i_q ? ram_rdata : 32'h0;
        conflict_cnt = conflict_cnt_q;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: SRAM behavioural model, transaction-level
// reference model, directed scenarios and a randomized protocol-legal run.
module tb_sram_arbiter;

    localparam int SMAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        d_req, i_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr, d_wdata, i_addr;
    logic [31:0] ram_rdata;

    logic        d_gnt, d_rvalid, i_gnt, i_rvalid, ram_en;
    logic [31:0] d_rdata, i_rdata, ram_addr, ram_wdata;
    logic [3:0]  ram_we;
    logic [15:0] conflict_cnt;

    logic        d_gnt1, d_rvalid1, i_gnt1, i_rvalid1, ram_en1;
    logic [31:0] d_rdata1, i_rdata1, ram_addr1, ram_wdata1;
    logic [3:0]  ram_we1;
    logic [15:0] conflict_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    sram_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
    );

    // Second instance with the tightest starvation bound, fed the same inputs
    sram_arbiter #(.STARVE_MAX(1)) dut1 (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_wdata(ram_wdata1),
        .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt1)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // SRAM macro model: one-cycle read latency, byte-masked writes
    logic [31:0] sram_mem [1024];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we != 4'h0) sram_mem[ram_addr[11:2]] = merge(sram_mem[ram_addr[11:2]], ram_wdata, ram_we);
            else                ram_rdata <= sram_mem[ram_addr[11:2]];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [1024];
    bit          m_pd, m_pi;
    logic [31:0] m_pdata, m_pidata;
    int          m_starve, m_starve1, m_conf;

    // Expected values for the current cycle
    logic        e_dg, e_ig, e_en, e_ig1, e_dg1;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_drd, e_ird;
    logic        e_drv, e_irv;
    logic [15:0] e_conf;

    task automatic model_expect();
        if (reset) begin
            e_dg = 0; e_ig = 0; e_dg1 = 0; e_ig1 = 0;
        end else begin
            // fetch wins only when alone or after waiting the full bound
            e_ig  = i_req && (!d_req || m_starve >= SMAX);
            e_dg  = d_req && !e_ig;
            e_ig1 = i_req && (!d_req || m_starve1 >= 1);
            e_dg1 = d_req && !e_ig1;
        end
        e_en   = e_dg | e_ig;
        e_we   = e_dg ? d_we : 4'h0;
        e_addr = e_ig ? i_addr : d_addr;
        e_drv  = m_pd;
        e_irv  = m_pi;
        e_drd  = m_pd ? m_pdata : 32'h0;
        e_ird  = m_pi ? m_pidata : 32'h0;
        e_conf = 16'(m_conf);
    endtask

    task automatic model_update();
        if (reset) begin
            m_pd = 0; m_pi = 0; m_starve = 0; m_starve1 = 0; m_conf = 0;
        end else begin
            m_pd = e_dg && (d_we == 4'h0);
            if (m_pd) m_pdata = ref_mem[d_addr[11:2]];
            if (e_dg && d_we != 4'h0) ref_mem[d_addr[11:2]] = merge(ref_mem[d_addr[11:2]], d_wdata, d_we);
            m_pi = e_ig;
            if (e_ig) m_pidata = ref_mem[i_addr[11:2]];
            if (i_req && !e_ig)  m_starve  = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
            else                 m_starve  = 0;
            if (i_req && !e_ig1) m_starve1 = 1;
            else                 m_starve1 = 0;
            if (d_req && i_req && m_conf < 65535) m_conf++;
        end
    endtask

    task automatic drive(input logic r, input logic dr, input logic [3:0] we,
                         input logic [31:0] da, input logic [31:0] dw,
                         input logic ir, input logic [31:0] ia);
        reset = r; d_req = dr; d_we = we; d_addr = da; d_wdata = dw; i_req = ir; i_addr = ia;
        model_expect();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 4'h0, 32'h100, 0, 1, 32'h40);
            @(negedge clk);
            n_checks++;
            if ({d_gnt, i_gnt, ram_en, ram_we} !== 7'b0) begin
                n_errors++;
                $display("FAIL reset_grants cyc %0d: got %b, need 0", k, {d_gnt, i_gnt, ram_en, ram_we});
            end
            advance();
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 4'h0, 0, 0, 0, 0);
            @(negedge clk);
            n_checks++;
            if ({d_gnt, i_gnt, ram_en, ram_we, d_rvalid, i_rvalid} !== 9'b0 ||
                d_rdata !== 32'h0 || i_rdata !== 32'h0 || conflict_cnt !== 16'h0) begin
                n_errors++;
                $display("FAIL reset_idle cyc %0d: ctl %b drd %h ird %h cc %0d, need all 0", k,
                         {d_gnt, i_gnt, ram_en, ram_we, d_rvalid, i_rvalid}, d_rdata, i_rdata, conflict_cnt);
            end
            advance();
        end
    endtask

    task automatic test_load();
        drive(0, 1, 4'h0, 32'h100, 32'h0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || ram_en !== 1'b1 || ram_we !== 4'h0 || ram_addr !== 32'h100) begin
            n_errors++;
            $display("FAIL load_grant: dg %b ig %b en %b we %h addr %h, need 1 0 1 0 00000100",
                     d_gnt, i_gnt, ram_en, ram_we, ram_addr);
        end
        advance();
        drive(0, 0, 4'h0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF || i_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL load_resp: drv %b drd %h irv %b, need 1 deadbeef 0", d_rvalid, d_rdata, i_rvalid);
        end
        advance();
    endtask

    task automatic test_store_load();
        drive(0, 1, 4'hF, 32'h200, 32'h12345678, 0, 0);
        @(negedge clk);
        n_checks++;
        if (d_gnt !== 1'b1 || ram_we !== 4'hF || ram_wdata !== 32'h12345678 || ram_addr !== 32'h200) begin
            n_errors++;
            $display("FAIL store_grant: dg %b we %h wd %h addr %h", d_gnt, ram_we, ram_wdata, ram_addr);
        end
        advance();
        drive(0, 1, 4'h0, 32'h200, 32'h0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (d_rvalid !== 1'b0 || d_gnt !== 1'b1 || ram_we !== 4'h0) begin
            n_errors++;
            $display("FAIL store_no_rvalid: drv %b dg %b we %h, need 0 1 0", d_rvalid, d_gnt, ram_we);
        end
        advance();
        drive(0, 0, 4'h0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h12345678) begin
            n_errors++;
            $display("FAIL store_load_resp: drv %b drd %h, need 1 12345678", d_rvalid, d_rdata);
        end
        advance();
    endtask

    task automatic test_contention();
        logic [31:0] ia;
        ia = 32'h1C000000;
        for (int k = 0; k < 20; k++) begin
            drive(0, 1, 4'h0, 32'h100 + 32'($urandom_range(0, 3)) * 4, 0, 1, ia);
            @(negedge clk);
            n_checks++;
            if (i_gnt !== ((k % 5) == 4) || d_gnt !== ((k % 5) != 4) || i_gnt !== e_ig) begin
                n_errors++;
                $display("FAIL contention_pattern cyc %0d: dg %b ig %b, need ig %b", k, d_gnt, i_gnt, (k % 5) == 4);
            end
            n_checks++;
            if (i_gnt1 !== ((k % 2) == 1) || d_gnt1 !== ((k % 2) == 0)) begin
                n_errors++;
                $display("FAIL contention_alt1 cyc %0d: dg1 %b ig1 %b, need ig1 %b", k, d_gnt1, i_gnt1, (k % 2) == 1);
            end
            n_checks++;
            if (d_rvalid !== e_drv || d_rdata !== e_drd || i_rvalid !== e_irv || i_rdata !== e_ird) begin
                n_errors++;
                $display("FAIL contention_resp cyc %0d: drv %b drd %h irv %b ird %h, need %b %h %b %h", k,
                         d_rvalid, d_rdata, i_rvalid, i_rdata, e_drv, e_drd, e_irv, e_ird);
            end
            advance();
            if (e_ig) ia = 32'h1C000000 + 32'($urandom_range(0, 15)) * 4;
        end
        drive(0, 0, 4'h0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (conflict_cnt !== 16'd20 || conflict_cnt !== e_conf) begin
            n_errors++;
            $display("FAIL contention_count: got %0d, need 20", conflict_cnt);
        end
        advance();
    endtask

    task automatic test_fetch_alone();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 4'h0, 32'h0, 0, k < 3, 32'h1C000000);
            @(negedge clk);
            n_checks++;
            if (i_gnt !== (k < 3) || d_gnt !== 1'b0 || i_rvalid !== (k >= 1 && k <= 3) ||
                i_rdata !== e_ird || (k < 3 && ram_addr !== 32'h1C000000)) begin
                n_errors++;
                $display("FAIL fetch_alone cyc %0d: ig %b dg %b irv %b ird %h addr %h, need ird %h", k,
                         i_gnt, d_gnt, i_rvalid, i_rdata, ram_addr, e_ird);
            end
            n_checks++;
            if (d_rvalid !== 1'b0) begin
                n_errors++;
                $display("FAIL fetch_alone_drv cyc %0d: got %b, need 0", k, d_rvalid);
            end
            advance();
        end
        // starvation count must be zero: four data wins before fetch is forced
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 4'h0, 32'h100, 0, 1, 32'h1C000000);
            @(negedge clk);
            n_checks++;
            if (i_gnt !== (k == 4)) begin
                n_errors++;
                $display("FAIL fetch_starve_zero cyc %0d: ig %b, need %b", k, i_gnt, k == 4);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_read();
        drive(0, 0, 4'h0, 0, 0, 0, 0);
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 4'h0, 32'h100, 0, 1, 32'h180);
            @(negedge clk);
            n_checks++;
            if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
                n_errors++;
                $display("FAIL rmr_pre cyc %0d: dg %b ig %b, need 1 0", k, d_gnt, i_gnt);
            end
            advance();
        end
        drive(1, 1, 4'h0, 32'h100, 0, 1, 32'h180);
        @(negedge clk);
        n_checks++;
        if ({d_gnt, i_gnt, ram_en} !== 3'b0) begin
            n_errors++;
            $display("FAIL rmr_in_reset: dg %b ig %b en %b, need 0", d_gnt, i_gnt, ram_en);
        end
        advance();
        drive(0, 0, 4'h0, 0, 0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || d_rdata !== 32'h0 || conflict_cnt !== 16'h0) begin
            n_errors++;
            $display("FAIL rmr_after: drv %b irv %b drd %h cc %0d, need 0 0 0 0", d_rvalid, i_rvalid, d_rdata, conflict_cnt);
        end
        advance();
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 4'h0, 32'h100, 0, 1, 32'h180);
            @(negedge clk);
            n_checks++;
            if (i_gnt !== (k == 4)) begin
                n_errors++;
                $display("FAIL rmr_starve_cleared cyc %0d: ig %b, need %b", k, i_gnt, k == 4);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic        dp, ip;
        logic [3:0]  we;
        logic [31:0] da, dw, ia;
        logic        r;
        dp = 0; ip = 0; we = 0; da = 0; dw = 0; ia = 0;
        for (int k = 0; k < 400; k++) begin
            if (!dp && $urandom_range(0, 9) < 6) begin
                dp = 1;
                we = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                da = 32'h300 + 32'($urandom_range(0, 7)) * 4;
                dw = $urandom;
            end
            if (!ip && $urandom_range(0, 9) < 6) begin
                ip = 1;
                ia = 32'h300 + 32'($urandom_range(0, 7)) * 4;
            end
            r = ($urandom_range(0, 49) == 0);
            drive(r, dp, we, da, dw, ip, ia);
            @(negedge clk);
            n_checks++;
            if ({d_gnt, i_gnt, ram_en, ram_we} !== {e_dg, e_ig, e_en, e_we} ||
                (e_en && ram_addr !== e_addr) || (e_dg && ram_wdata !== d_wdata)) begin
                n_errors++;
                $display("FAIL rnd_req cyc %0d: dg %b ig %b en %b we %h addr %h, need %b %b %b %h %h", k,
                         d_gnt, i_gnt, ram_en, ram_we, ram_addr, e_dg, e_ig, e_en, e_we, e_addr);
            end
            n_checks++;
            if ({d_gnt1, i_gnt1} !== {e_dg1, e_ig1}) begin
                n_errors++;
                $display("FAIL rnd_s1 cyc %0d: dg1 %b ig1 %b, need %b %b", k, d_gnt1, i_gnt1, e_dg1, e_ig1);
            end
            if (!r) begin
                n_checks++;
                if (d_rvalid !== e_drv || d_rdata !== e_drd || i_rvalid !== e_irv ||
                    i_rdata !== e_ird || conflict_cnt !== e_conf) begin
                    n_errors++;
                    $display("FAIL rnd_resp cyc %0d: drv %b drd %h irv %b ird %h cc %0d, need %b %h %b %h %0d", k,
                             d_rvalid, d_rdata, i_rvalid, i_rdata, conflict_cnt, e_drv, e_drd, e_irv, e_ird, e_conf);
                end
            end
            advance();
            if (e_dg) dp = 0;
            if (e_ig) ip = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = 32'h0;
            ref_mem[i]  = 32'h0;
        end
        sram_mem[10'h040] = 32'hDEADBEEF;  ref_mem[10'h040] = 32'hDEADBEEF;
        sram_mem[10'h000] = 32'hCAFEF00D;  ref_mem[10'h000] = 32'hCAFEF00D;
        for (int i = 1; i < 16; i++) begin
            sram_mem[i] = 32'hA5000000 + 32'(i);
            ref_mem[i]  = 32'hA5000000 + 32'(i);
        end
        m_pd = 0; m_pi = 0; m_pdata = 0; m_pidata = 0;
        m_starve = 0; m_starve1 = 0; m_conf = 0;
        test_reset();
        test_load();
        test_store_load();
        test_contention();
        test_fetch_alone();
        test_reset_mid_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
